// File: rtl/mult_controller_pkg.sv
// Shared types for the shift-add multiplier sequencer: state encoding and
// the Moore output decode used by mult_controller.
// Ports: none (package only).
package mult_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Control word driven to the datapath. Bit order is fixed so the whole
  // word can be compared or logged as one 6-bit value.
  typedef struct packed {
    logic busy;
    logic done;
    logic load_en;
    logic clear_hi;
    logic add_en;
    logic shift_en;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE  = 6'b000000;
  localparam ctrl_t CTRL_LOAD  = 6'b101100;
  localparam ctrl_t CTRL_TEST  = 6'b100000;
  localparam ctrl_t CTRL_ADD   = 6'b100010;
  localparam ctrl_t CTRL_SHIFT = 6'b100001;
  localparam ctrl_t CTRL_DONE  = 6'b110000;

  // Moore decode: each state maps to exactly one control word, which keeps
  // load/add/shift mutually exclusive by construction.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    case (s)
      S_LOAD:  c = CTRL_LOAD;
      S_TEST:  c = CTRL_TEST;
      S_ADD:   c = CTRL_ADD;
      S_SHIFT: c = CTRL_SHIFT;
      S_DONE:  c = CTRL_DONE;
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the shift-add multiplier: synchronous clear,
// increment enable, asynchronous active-high Reset. Output is registered.
// Latency: count updates one Clk after clr/inc; last is combinational from count.
// Ports: Clk, Reset, clr, inc in; count[CNT_W], last (count == WIDTH-1) out.
module mult_iter_counter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_controller.sv
// Sequencer for the shift-add multiplier: LOAD, then WIDTH x (TEST, [ADD], SHIFT), then a one-cycle DONE.
// Latency: Done is high in the cycle after edge 1+2*WIDTH+popcount(multiplier), edge 0 = Start accepted.
// Backpressure: none; Start is only sampled in IDLE and ignored while Busy.
// Ports: Clk, Reset (async, active-high), Start, ProdLsb in;
//        Busy, Done, LoadEn, ClearHi, AddEn, ShiftEn, Count[CNT_W] out (all registered).
module mult_controller
  import mult_controller_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             ProdLsb,
  output logic             Busy,
  output logic             Done,
  output logic             LoadEn,
  output logic             ClearHi,
  output logic             AddEn,
  output logic             ShiftEn,
  output logic [CNT_W-1:0] Count
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

  // Counter is cleared while LOAD is on the bus so TEST of iteration 0 sees 0.
  // On the final SHIFT the count is held at WIDTH-1 instead of wrapping.
  assign cnt_clr = (state_q == S_LOAD);
  assign cnt_inc = (state_q == S_SHIFT) && !cnt_last;

  mult_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (Count),
    .last  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_LOAD;
      S_LOAD:  state_d = S_TEST;
      // ProdLsb is only looked at here; TEST always follows LOAD or SHIFT,
      // giving the datapath a full cycle to settle the new LSB.
      S_TEST:  state_d = ProdLsb ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = cnt_last ? S_DONE : S_TEST;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are decoded from the next state and registered, so each enable
    // is a clean flop output for the whole cycle of its state.
    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ctrl_q  <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign Busy    = ctrl_q.busy;
  assign Done    = ctrl_q.done;
  assign LoadEn  = ctrl_q.load_en;
  assign ClearHi = ctrl_q.clear_hi;
  assign AddEn   = ctrl_q.add_en;
  assign ShiftEn = ctrl_q.shift_en;

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller: a WIDTH=4 and a WIDTH=32 instance, each driving
// a shift-add datapath model that supplies ProdLsb and yields the product.
// Ports: none (top-level bench).
module tb_mult_controller;

  typedef struct {
    bit          sel;       // 0: WIDTH=4 instance, 1: WIDTH=32 instance
    logic [31:0] a;         // multiplicand
    logic [31:0] m;         // multiplier
    bit          hold;      // keep Start high into the IDLE cycle after DONE
    bit          cont;      // Start already held by the previous operation
    bit          noise;     // random Start toggling while busy
    int          exp_done;  // edge after which Done is high
    int          exp_adds;
    logic [63:0] exp_prod;
  } vec_t;

  typedef struct {
    logic [5:0] c;    // {busy,done,load,clear,add,shift}
    int         n;    // expected Count
    bit         chk;  // Count checked in this cycle
  } step_t;

  typedef struct packed {
    logic [63:0] mc;
    logic [63:0] hi;
    logic [63:0] lo;
    logic        cy;
  } dp_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  logic start4  = 1'b0;
  logic start32 = 1'b0;
  logic b4, d4, l4, c4, a4, s4;
  logic b32, d32, l32, c32, a32, s32;
  logic [2:0] cnt4;
  logic [5:0] cnt32;
  logic lsb4, lsb32;
  logic pd4 = 1'b0;
  logic pd32 = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] opa [2];
  logic [31:0] opb [2];
  dp_t dp [2];

  always #5 Clk = ~Clk;

  mult_controller #(.WIDTH(4), .CNT_W(3)) u4 (
    .Clk(Clk), .Reset(Reset), .Start(start4), .ProdLsb(lsb4),
    .Busy(b4), .Done(d4), .LoadEn(l4), .ClearHi(c4), .AddEn(a4), .ShiftEn(s4),
    .Count(cnt4)
  );

  mult_controller #(.WIDTH(32), .CNT_W(6)) u32 (
    .Clk(Clk), .Reset(Reset), .Start(start32), .ProdLsb(lsb32),
    .Busy(b32), .Done(d32), .LoadEn(l32), .ClearHi(c32), .AddEn(a32), .ShiftEn(s32),
    .Count(cnt32)
  );

  // Behavioural datapath: {carry, hi, lo} register chain of w-bit halves.
  function automatic dp_t dp_next(input dp_t s, input int w, input logic [31:0] a,
                                  input logic [31:0] m, input logic ld, input logic clr,
                                  input logic add, input logic sh);
    dp_t n;
    logic [63:0] mask;
    logic [64:0] sum;
    n = s;
    mask = (64'd1 << w) - 64'd1;
    if (ld) begin
      n.mc = {32'd0, a} & mask;
      n.lo = {32'd0, m} & mask;
    end
    if (clr) begin
      n.hi = 64'd0;
      n.cy = 1'b0;
    end
    if (add) begin
      sum  = {1'b0, s.hi} + {1'b0, s.mc};
      n.hi = sum[63:0] & mask;
      n.cy = sum[w];
    end
    if (sh) begin
      n.lo = (s.lo >> 1) | ((s.hi & 64'd1) << (w - 1));
      n.hi = (s.hi >> 1) | ({63'd0, s.cy} << (w - 1));
      n.cy = 1'b0;
    end
    return n;
  endfunction

  always @(posedge Clk) begin
    dp[0] <= dp_next(dp[0], 4, opa[0], opb[0], l4, c4, a4, s4);
    dp[1] <= dp_next(dp[1], 32, opa[1], opb[1], l32, c32, a32, s32);
  end

  assign lsb4  = dp[0].lo[0];
  assign lsb32 = dp[1].lo[0];

  function automatic logic [5:0] ctrl_of(input bit sel);
    return sel ? {b32, d32, l32, c32, a32, s32} : {b4, d4, l4, c4, a4, s4};
  endfunction

  function automatic int cnt_of(input bit sel);
    return sel ? int'(cnt32) : int'(cnt4);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start32 = v;
    else     start4  = v;
  endtask

  task automatic invariants(input string nm, input logic [5:0] c, input logic pd);
    check({nm, " enable exclusivity"}, 64'($countones({c[3], c[1], c[0]}) > 1), 64'd0);
    check({nm, " clear without load"}, 64'(c[2] & ~c[3]), 64'd0);
    check({nm, " output while not busy"}, 64'(!c[5] && (c != 6'd0)), 64'd0);
    check({nm, " done wider than 1"}, 64'(c[4] & pd), 64'd0);
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      invariants("u4", ctrl_of(1'b0), pd4);
      invariants("u32", ctrl_of(1'b1), pd32);
    end
    pd4  <= d4;
    pd32 <= d32;
  end

  // One full operation, checked cycle by cycle against the expected sequence
  // LOAD, per bit TEST[,ADD],SHIFT, DONE, then one IDLE cycle.
  task automatic run_op(input vec_t v, input string tag);
    step_t tr [$];
    int w, done_k, adds, shifts;
    logic [5:0] c;
    logic [63:0] prod;
    w = v.sel ? 32 : 4;
    tr.push_back('{c: 6'b101100, n: 0, chk: 1'b0});
    for (int i = 0; i < w; i++) begin
      tr.push_back('{c: 6'b100000, n: i, chk: 1'b1});
      if (v.m[i]) tr.push_back('{c: 6'b100010, n: i, chk: 1'b1});
      tr.push_back('{c: 6'b100001, n: i, chk: 1'b1});
    end
    tr.push_back('{c: 6'b110000, n: w - 1, chk: 1'b1});
    tr.push_back('{c: 6'b000000, n: w - 1, chk: 1'b1});

    opa[v.sel] = v.a;
    opb[v.sel] = v.m;
    if (!v.cont) begin
      @(negedge Clk);
      set_start(v.sel, 1'b1);
    end
    @(posedge Clk);
    done_k = -1;
    adds   = 0;
    shifts = 0;
    for (int k = 0; k < tr.size(); k++) begin
      @(negedge Clk);
      c = ctrl_of(v.sel);
      check($sformatf("%s ctrl cycle %0d", tag, k), 64'(c), 64'(tr[k].c));
      if (tr[k].chk)
        check($sformatf("%s count cycle %0d", tag, k), 64'(cnt_of(v.sel)), 64'(tr[k].n));
      if (c[4] && done_k < 0) done_k = k;
      adds   += int'(c[1]);
      shifts += int'(c[0]);
      if (k == tr.size() - 1) set_start(v.sel, v.hold);
      else set_start(v.sel, v.noise ? 1'($urandom_range(0, 1)) : v.hold);
    end
    prod = v.sel ? ((dp[1].hi << 32) | dp[1].lo) : ((dp[0].hi << 4) | dp[0].lo);
    check({tag, " done edge"}, 64'(done_k), 64'(v.exp_done));
    check({tag, " add pulses"}, 64'(adds), 64'(v.exp_adds));
    check({tag, " shift pulses"}, 64'(shifts), 64'(w));
    check({tag, " product"}, prod, v.exp_prod);
  endtask

  initial begin
    vec_t tbl [12];
    vec_t rv;
    logic seen_done;
    int w;

    tbl[0] = '{sel: 0, a: 7, m: 0, hold: 0, cont: 0, noise: 0,
               exp_done: 9, exp_adds: 0, exp_prod: 64'd0};
    tbl[1] = '{sel: 0, a: 7, m: 5, hold: 0, cont: 0, noise: 0,
               exp_done: 11, exp_adds: 2, exp_prod: 64'd35};
    tbl[2] = '{sel: 1, a: 32'hFFFFFFFF, m: 32'hFFFFFFFF, hold: 0, cont: 0, noise: 0,
               exp_done: 97, exp_adds: 32, exp_prod: 64'hFFFFFFFE00000001};
    tbl[3] = '{sel: 0, a: 3, m: 6, hold: 1, cont: 0, noise: 0,
               exp_done: 11, exp_adds: 2, exp_prod: 64'd18};
    tbl[4] = '{sel: 0, a: 3, m: 6, hold: 0, cont: 1, noise: 0,
               exp_done: 11, exp_adds: 2, exp_prod: 64'd18};
    tbl[5] = '{sel: 1, a: 32'h12345678, m: 32'h0000000F, hold: 0, cont: 0, noise: 1,
               exp_done: 69, exp_adds: 4, exp_prod: 64'h111111108};
    for (int i = 6; i < 12; i++) begin
      tbl[i].sel   = 1'($urandom_range(0, 1));
      tbl[i].a     = $urandom;
      tbl[i].m     = $urandom;
      if (!tbl[i].sel) begin
        tbl[i].a = tbl[i].a & 32'hF;
        tbl[i].m = tbl[i].m & 32'hF;
      end
      w = tbl[i].sel ? 32 : 4;
      tbl[i].hold     = 1'b0;
      tbl[i].cont     = 1'b0;
      tbl[i].noise    = 1'($urandom_range(0, 1));
      tbl[i].exp_adds = $countones(tbl[i].m);
      tbl[i].exp_done = 1 + 2 * w + tbl[i].exp_adds;
      tbl[i].exp_prod = 64'(tbl[i].a) * 64'(tbl[i].m);
    end

    // Reset state
    #1 Reset = 1'b1;
    #2;
    check("reset ctrl u4", 64'(ctrl_of(1'b0)), 64'd0);
    check("reset ctrl u32", 64'(ctrl_of(1'b1)), 64'd0);
    check("reset count u4", 64'(cnt4), 64'd0);
    check("reset count u32", 64'(cnt32), 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Reset in the 10th cycle of an operation (multiplier 1111: a SHIFT, Count=2)
    opa[0] = 32'd5;
    opb[0] = 32'd15;
    @(negedge Clk);
    start4 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start4 = 1'b0;
    repeat (9) @(negedge Clk);
    check("pre-reset ctrl", 64'(ctrl_of(1'b0)), 64'b100001);
    check("pre-reset count", 64'(cnt4), 64'd2);
    #2 Reset = 1'b1;
    #1;
    check("async reset ctrl", 64'(ctrl_of(1'b0)), 64'd0);
    check("async reset count", 64'(cnt4), 64'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (k == 2) Reset = 1'b0;
      seen_done |= d4;
      check($sformatf("abort quiet cycle %0d", k), 64'(ctrl_of(1'b0)), 64'd0);
    end
    check("abort produced done", 64'(seen_done), 64'd0);
    rv = '{sel: 0, a: 5, m: 15, hold: 0, cont: 0, noise: 1,
           exp_done: 13, exp_adds: 4, exp_prod: 64'd75};
    run_op(rv, "post-reset");

    repeat (2) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1, "time limit");
  end

endmodule
